mc6800_cycle_ctrl: RTL



---
 rtl/mc6800_pkg.sv | 33 +++
 rtl/mc6800_e_phase_gen.sv | 54 +++++
 rtl/mc6800_cycle_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mc6800_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc6800_pkg
//  Purpose  : Shared types and constants for the 6800-peripheral bus-cycle
//             controller: cycle state enum, CPU-space function code and the
//             default timing parameters.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mc6800_pkg;

    // Bus-cycle tracking states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_AVEC   = 3'd3,
        ST_HOLD   = 3'd4
    } cyc_state_t;

    // Function code of an interrupt-acknowledge (CPU space) cycle
    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    // Default timing, in MB_CLK cycles / phase numbers
    localparam int E_DIV_DEFAULT        = 10;
    localparam int E_RISE_DEFAULT       = 6;
    localparam int E_FALL_DEFAULT       = 10;
    localparam int VMA_PHASE_DEFAULT    = 2;
    localparam int DTACK_PHASE_DEFAULT  = 8;
    localparam int TIMEOUT_CLKS_DEFAULT = 64;

endpackage
`default_nettype wire

// File: rtl/mc6800_e_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mc6800_e_phase_gen
//  Purpose  : Free-running E-clock phase counter. Counts 0..E_DIV-1, exposes
//             the phase that will be loaded at the coming edge (phase_next)
//             and a registered E clock that is high for E_RISE <= P < E_FALL.
//  Ports    : clk        in   clock (MB_CLK)
//             rst        in   synchronous active-high reset
//             phase      out  current phase P
//             phase_next out  value P takes at the coming edge
//             e_clk      out  registered E clock
//  Revision : 1.0 - initial release
// ============================================================================
module mc6800_e_phase_gen #(
    parameter int E_DIV  = 10,
    parameter int E_RISE = 6,
    parameter int E_FALL = 10,
    parameter int PW     = $clog2(E_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [PW-1:0] phase,
    output logic [PW-1:0] phase_next,
    output logic          e_clk
);

    localparam logic [PW-1:0] C_LAST = PW'(E_DIV - 1);
    // One extra bit so E_FALL == E_DIV stays representable for any E_DIV
    localparam logic [PW:0]   C_RISE = (PW+1)'(E_RISE);
    localparam logic [PW:0]   C_FALL = (PW+1)'(E_FALL);

    logic [PW-1:0] r_phase;
    logic          r_e_clk;
    logic [PW:0]   w_next_ext;

    assign phase_next = (r_phase == C_LAST) ? '0 : r_phase + PW'(1);
    assign w_next_ext = {1'b0, phase_next};

    // E is registered from phase_next so it is aligned with the P it describes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_e_clk <= 1'b0;
        end else begin
            r_phase <= phase_next;
            r_e_clk <= (w_next_ext >= C_RISE) && (w_next_ext < C_FALL);
        end
    end

    assign phase = r_phase;
    assign e_clk = r_e_clk;

endmodule
`default_nettype wire

// File: rtl/mc6800_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc6800_cycle_ctrl
//  Purpose  : 6800-peripheral bus-cycle controller. Generates E from MB_CLK,
//             tracks VPA-terminated cycles, drives VMA and the card-side
//             DTACK, terminates CPU-space VPA cycles without VMA and, when
//             MC6800_BERR_TIMEOUT_EN is defined, flags hung cycles with BERR.
//  Ports    : MB_CLK       in   sole clock, rising edge
//             RESET        in   synchronous active-high reset
//             CPU_AS       in   address strobe, active-low
//             CPU_FC[2:0]  in   function code (3'b111 = CPU space)
//             MB_VPA       in   valid peripheral address, active-low
//             MB_DTACK     in   motherboard DTACK, active-low (watchdog only)
//             MB_E_CLK     out  E clock
//             MB_VMA       out  valid memory address, active-low
//             MC6800_DTACK out  cycle termination to CPU, active-low
//             CPU_BERR     out  bus error, active-low
//             E_PHASE      out  current E phase
//  Macro    : MC6800_BERR_TIMEOUT_EN - enables the watchdog / CPU_BERR
//  Revision : 1.0 - initial release
// ============================================================================
module mc6800_cycle_ctrl
    import mc6800_pkg::*;
#(
    parameter int E_DIV        = E_DIV_DEFAULT,
    parameter int E_RISE       = E_RISE_DEFAULT,
    parameter int E_FALL       = E_FALL_DEFAULT,
    parameter int VMA_PHASE    = VMA_PHASE_DEFAULT,
    parameter int DTACK_PHASE  = DTACK_PHASE_DEFAULT,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
) (
    input  logic                     MB_CLK,
    input  logic                     RESET,
    input  logic                     CPU_AS,
    input  logic [2:0]               CPU_FC,
    input  logic                     MB_VPA,
    input  logic                     MB_DTACK,
    output logic                     MB_E_CLK,
    output logic                     MB_VMA,
    output logic                     MC6800_DTACK,
    output logic                     CPU_BERR,
    output logic [$clog2(E_DIV)-1:0] E_PHASE
);

    localparam int            PW      = $clog2(E_DIV);
    localparam logic [PW-1:0] C_VMA   = PW'(VMA_PHASE);
    localparam logic [PW-1:0] C_DTACK = PW'(DTACK_PHASE);

    logic [PW-1:0] w_p_next;
    cyc_state_t    r_state, w_state_next;
    logic          r_vma, w_vma_next;
    logic          r_dtack, w_dtack_next;

    mc6800_e_phase_gen #(
        .E_DIV  (E_DIV),
        .E_RISE (E_RISE),
        .E_FALL (E_FALL),
        .PW     (PW)
    ) u_phase (
        .clk        (MB_CLK),
        .rst        (RESET),
        .phase      (E_PHASE),
        .phase_next (w_p_next),
        .e_clk      (MB_E_CLK)
    );

    always_ff @(posedge MB_CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_vma   <= 1'b1;
            r_dtack <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_vma   <= w_vma_next;
            r_dtack <= w_dtack_next;
        end
    end

    // All phase decisions look at w_p_next so the registered outputs change
    // exactly on the edge that enters the named phase.
    always_comb begin
        w_state_next = r_state;
        w_vma_next   = r_vma;
        w_dtack_next = r_dtack;
        if (CPU_AS) begin
            // AS negation aborts/ends any cycle and releases both strobes
            w_state_next = ST_IDLE;
            w_vma_next   = 1'b1;
            w_dtack_next = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!MB_VPA) begin
                        if (CPU_FC == FC_CPU_SPACE) begin
                            w_state_next = ST_AVEC;
                        end else if (w_p_next == C_VMA) begin
                            w_state_next = ST_ACTIVE;
                            w_vma_next   = 1'b0;
                        end else begin
                            w_state_next = ST_SYNC;
                        end
                    end
                end
                ST_SYNC: begin
                    if (w_p_next == C_VMA) begin
                        w_state_next = ST_ACTIVE;
                        w_vma_next   = 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_p_next == C_DTACK) begin
                        w_dtack_next = 1'b0;
                    end
                    if (w_p_next == '0) begin
                        w_vma_next   = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
                ST_AVEC: begin
                    if (w_p_next == C_DTACK) begin
                        w_dtack_next = 1'b0;
                        w_state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // DTACK stays asserted until AS is released
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_vma_next   = 1'b1;
                    w_dtack_next = 1'b1;
                end
            endcase
        end
    end

    assign MB_VMA       = r_vma;
    assign MC6800_DTACK = r_dtack;

`ifdef MC6800_BERR_TIMEOUT_EN
    localparam int            CW        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT_CLKS);

    logic [CW-1:0] r_wd_cnt, w_wd_next;
    logic          r_berr;

    // Counts only while nobody is terminating the cycle; saturates so BERR
    // holds until AS is released.
    always_comb begin
        w_wd_next = r_wd_cnt;
        if (CPU_AS) begin
            w_wd_next = '0;
        end else if (MB_DTACK && r_dtack && (r_wd_cnt != C_TIMEOUT)) begin
            w_wd_next = r_wd_cnt + CW'(1);
        end
    end

    always_ff @(posedge MB_CLK) begin
        if (RESET) begin
            r_wd_cnt <= '0;
            r_berr   <= 1'b1;
        end else begin
            r_wd_cnt <= w_wd_next;
            r_berr   <= (w_wd_next != C_TIMEOUT);
        end
    end

    assign CPU_BERR = r_berr;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = MB_DTACK ^ (TIMEOUT_CLKS >= 2 * E_DIV);
    assign CPU_BERR     = 1'b1;
`endif

endmodule
`default_nettype wire
